// File: rtl/sha_final_padding_gen_if.sv
// Host/core-side bundle for the SHA final padding generator.
// master: block-feeding host (drives commands, block data, core_ready mirror)
// slave : padding generator (drives ready, strobes, block_out, len_error)
// Ports: init_in/next_in/final_in commands, final_len, block_in, core_ready,
//        ready, init_out, next_out, block_out, len_error.
interface sha_final_padding_gen_if #(
   parameter int BLOCK_BITS = 512,
   parameter int LEN_BITS   = 64,
   parameter int FLW        = $clog2(BLOCK_BITS) + 1
);
   logic                  init_in;
   logic                  next_in;
   logic                  final_in;
   logic [FLW-1:0]        final_len;
   logic [BLOCK_BITS-1:0] block_in;
   logic                  core_ready;
   logic                  ready;
   logic                  init_out;
   logic                  next_out;
   logic [BLOCK_BITS-1:0] block_out;
   logic                  len_error;

   modport master (
      output init_in, next_in, final_in, final_len, block_in, core_ready,
      input  ready, init_out, next_out, block_out, len_error
   );

   modport slave (
      input  init_in, next_in, final_in, final_len, block_in, core_ready,
      output ready, init_out, next_out, block_out, len_error
   );
endinterface

// File: rtl/sha_final_padding_gen.sv
// Final-block padding generator for SHA-256 (512/64) and SHA-512 (1024/128).
// Tracks the message bit count, masks unused bits of the last block, inserts
// the '1' pad bit and the length field, and issues an extra length block when
// the last block has no room for it. Outputs are registered; strobes follow
// the accepting edge by one cycle.
// Ports: clk, reset_n (async, active-low), bus (slave side of
//        sha_final_padding_gen_if).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | accepting commands when ready
// WAIT_LO | final block issued, waiting for core to go busy
// WAIT_HI | waiting for core idle before issuing the extra length block
module sha_final_padding_gen #(
   parameter int BLOCK_BITS = 512,
   parameter int LEN_BITS   = 64,
   parameter int FLW        = $clog2(BLOCK_BITS) + 1
) (
   input  logic clk,
   input  logic reset_n,
   sha_final_padding_gen_if.slave bus
);

   localparam int LW1 = LEN_BITS + 1;
   localparam logic [LW1-1:0]        BLK_INC   = LW1'(BLOCK_BITS);
   localparam logic [FLW-1:0]        BLK_LEN   = FLW'(BLOCK_BITS);
   localparam logic [FLW-1:0]        SHORT_LIM = FLW'(BLOCK_BITS - LEN_BITS);
   localparam logic [BLOCK_BITS-1:0] ONES      = '1;
   localparam logic [BLOCK_BITS-1:0] TOP_BIT   = {1'b1, {(BLOCK_BITS-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI} state_t;

   state_t                state, state_nxt;
   logic [LEN_BITS-1:0]   counter, counter_nxt;
   logic [LEN_BITS-1:0]   msg_len_q, msg_len_nxt;
   logic                  first, first_nxt;
   logic                  pad_pending, pad_pending_nxt;
   logic                  len_error, len_error_nxt;
   logic                  init_out, init_nxt;
   logic                  next_out, next_nxt;
   logic [BLOCK_BITS-1:0] block_out, block_nxt;

   logic                  ready;
   logic [LW1-1:0]        next_sum;
   logic [LW1-1:0]        final_sum;
   logic [BLOCK_BITS-1:0] padded;
   logic                  len_ok;
   logic                  fits_len;

   assign ready = (state == IDLE) & bus.core_ready & ~init_out & ~next_out;

   assign next_sum  = {1'b0, counter} + BLK_INC;
   assign final_sum = {1'b0, counter} + LW1'(bus.final_len);

   // Keep the top final_len bits, zero the rest, and drop the pad bit right
   // after the data. For final_len == BLOCK_BITS both shifts saturate, so the
   // block passes unchanged and no pad bit is placed.
   assign padded   = (bus.block_in & ~(ONES >> bus.final_len)) | (TOP_BIT >> bus.final_len);
   assign len_ok   = (bus.final_len <= BLK_LEN);
   assign fits_len = (bus.final_len < SHORT_LIM);

   always_comb begin
      state_nxt       = state;
      counter_nxt     = counter;
      msg_len_nxt     = msg_len_q;
      first_nxt       = first;
      pad_pending_nxt = pad_pending;
      len_error_nxt   = len_error;
      init_nxt        = 1'b0;
      next_nxt        = 1'b0;
      block_nxt       = block_out;

      if (bus.init_in) begin
         state_nxt     = IDLE;
         counter_nxt   = '0;
         first_nxt     = 1'b1;
         len_error_nxt = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ready && bus.final_in) begin
                  if (!len_ok) begin
                     len_error_nxt = 1'b1;
                  end else begin
                     init_nxt  = first;
                     next_nxt  = ~first;
                     first_nxt = 1'b0;
                     if (final_sum[LEN_BITS]) len_error_nxt = 1'b1;
                     if (fits_len) begin
                        block_nxt = {padded[BLOCK_BITS-1:LEN_BITS], final_sum[LEN_BITS-1:0]};
                     end else begin
                        block_nxt       = padded;
                        msg_len_nxt     = final_sum[LEN_BITS-1:0];
                        pad_pending_nxt = (bus.final_len == BLK_LEN);
                        state_nxt       = WAIT_LO;
                     end
                  end
               end else if (ready && bus.next_in) begin
                  block_nxt   = bus.block_in;
                  counter_nxt = next_sum[LEN_BITS-1:0];
                  init_nxt    = first;
                  next_nxt    = ~first;
                  first_nxt   = 1'b0;
                  if (next_sum[LEN_BITS]) len_error_nxt = 1'b1;
               end
            end
            WAIT_LO: begin
               if (!bus.core_ready) state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
               if (bus.core_ready) begin
                  block_nxt                 = '0;
                  block_nxt[BLOCK_BITS-1]   = pad_pending;
                  block_nxt[LEN_BITS-1:0]   = msg_len_q;
                  next_nxt                  = 1'b1;
                  state_nxt                 = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         counter     <= '0;
         msg_len_q   <= '0;
         first       <= 1'b0;
         pad_pending <= 1'b0;
         len_error   <= 1'b0;
         init_out    <= 1'b0;
         next_out    <= 1'b0;
         block_out   <= '0;
      end else begin
         state       <= state_nxt;
         counter     <= counter_nxt;
         msg_len_q   <= msg_len_nxt;
         first       <= first_nxt;
         pad_pending <= pad_pending_nxt;
         len_error   <= len_error_nxt;
         init_out    <= init_nxt;
         next_out    <= next_nxt;
         block_out   <= block_nxt;
      end
   end

   assign bus.ready     = ready;
   assign bus.init_out  = init_out;
   assign bus.next_out  = next_out;
   assign bus.block_out = block_out;
   assign bus.len_error = len_error;

endmodule

// File: tb/tb_sha_final_padding_gen.sv
module tb_sha_final_padding_gen;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // d=0: SHA-256 geometry, d=1: SHA-512 geometry, d=2: narrow counter for wrap tests
   sha_final_padding_gen_if #(.BLOCK_BITS(512),  .LEN_BITS(64))  if0 ();
   sha_final_padding_gen_if #(.BLOCK_BITS(1024), .LEN_BITS(128)) if1 ();
   sha_final_padding_gen_if #(.BLOCK_BITS(512),  .LEN_BITS(12))  if2 ();

   sha_final_padding_gen #(.BLOCK_BITS(512),  .LEN_BITS(64))  dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
   sha_final_padding_gen #(.BLOCK_BITS(1024), .LEN_BITS(128)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
   sha_final_padding_gen #(.BLOCK_BITS(512),  .LEN_BITS(12))  dut2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));

   int checks   = 0;
   int failures = 0;
   int bb[3] = '{512, 1024, 512};
   int ll[3] = '{64, 128, 12};

   logic [128:0] m_cnt[3];
   bit           m_first[3];
   bit           m_err[3];
   logic [127:0] m_len[3];
   int           m_flen[3];

   task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_blk(string tag, logic [1023:0] obs, logic [1023:0] exp);
      for (int s = 0; s < 4; s++)
         chk($sformatf("%s[%0d]", tag, s), obs[s*256 +: 256], exp[s*256 +: 256]);
   endtask

   function automatic logic [1023:0] get_blk(int d);
      case (d)
         0:       return {512'b0, if0.block_out};
         1:       return if1.block_out;
         default: return {512'b0, if2.block_out};
      endcase
   endfunction

   // {ready, init_out, next_out, len_error}
   function automatic logic [3:0] get_fl(int d);
      case (d)
         0:       return {if0.ready, if0.init_out, if0.next_out, if0.len_error};
         1:       return {if1.ready, if1.init_out, if1.next_out, if1.len_error};
         default: return {if2.ready, if2.init_out, if2.next_out, if2.len_error};
      endcase
   endfunction

   task automatic drive(int d, bit i, bit n, bit f, int flen, logic [1023:0] blk);
      case (d)
         0: begin
            if0.init_in = i; if0.next_in = n; if0.final_in = f;
            if0.final_len = 10'(flen); if0.block_in = blk[511:0];
         end
         1: begin
            if1.init_in = i; if1.next_in = n; if1.final_in = f;
            if1.final_len = 11'(flen); if1.block_in = blk;
         end
         default: begin
            if2.init_in = i; if2.next_in = n; if2.final_in = f;
            if2.final_len = 10'(flen); if2.block_in = blk[511:0];
         end
      endcase
   endtask

   task automatic set_cr(int d, bit v);
      case (d)
         0:       if0.core_ready = v;
         1:       if1.core_ready = v;
         default: if2.core_ready = v;
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1023:0] rnd_blk();
      logic [1023:0] b;
      for (int w = 0; w < 32; w++) b[w*32 +: 32] = $urandom;
      return b;
   endfunction

   // Reference: bit-by-bit construction of the padded final block.
   function automatic logic [1023:0] exp_first(int d, int flen, logic [1023:0] blk, logic [127:0] len);
      logic [1023:0] e = '0;
      int b = bb[d];
      int l = ll[d];
      for (int i = 0; i < b; i++) begin
         if (i < flen)       e[b-1-i] = blk[b-1-i];
         else if (i == flen) e[b-1-i] = 1'b1;
      end
      if (flen < b - l)
         for (int j = 0; j < l; j++) e[j] = len[j];
      return e;
   endfunction

   function automatic logic [1023:0] exp_extra(int d, int flen, logic [127:0] len);
      logic [1023:0] e = '0;
      if (flen == bb[d]) e[bb[d]-1] = 1'b1;
      for (int j = 0; j < ll[d]; j++) e[j] = len[j];
      return e;
   endfunction

   task automatic wait_ready(int d, string tag);
      logic [3:0] f;
      int n = 0;
      f = get_fl(d);
      while (f[3] !== 1'b1 && n < 20) begin
         step();
         n++;
         f = get_fl(d);
      end
      if (n == 20) chk({tag, "_ready_timeout"}, 256'(f[3]), 256'(1));
   endtask

   task automatic do_init(int d);
      logic [3:0] f;
      drive(d, 1, 0, 0, 0, '0);
      step();
      drive(d, 0, 0, 0, 0, '0);
      m_cnt[d] = '0; m_first[d] = 1; m_err[d] = 0;
      f = get_fl(d);
      chk("init_flags", 256'(f), 256'(4'b1000));
   endtask

   task automatic do_next(int d, logic [1023:0] blk);
      logic [3:0]    f;
      logic [128:0]  lim;
      logic [1023:0] e;
      wait_ready(d, "next");
      drive(d, 0, 1, 0, 0, blk);
      step();
      drive(d, 0, 0, 0, 0, '0);
      lim = 129'(1) << ll[d];
      m_cnt[d] = m_cnt[d] + 129'(bb[d]);
      if (m_cnt[d] >= lim) begin
         m_cnt[d] = m_cnt[d] - lim;
         m_err[d] = 1;
      end
      f = get_fl(d);
      chk("next_flags", 256'(f[2:0]), 256'({m_first[d], !m_first[d], m_err[d]}));
      m_first[d] = 0;
      e = '0;
      for (int i = 0; i < bb[d]; i++) e[i] = blk[i];
      chk_blk("next_blk", get_blk(d), e);
   endtask

   task automatic do_final(int d, int flen, logic [1023:0] blk, output bit extra);
      logic [3:0]   f;
      logic [128:0] lim, sum;
      logic [127:0] len;
      extra = 0;
      wait_ready(d, "final");
      drive(d, 0, 0, 1, flen, blk);
      step();
      drive(d, 0, 0, 0, 0, '0);
      f = get_fl(d);
      if (flen > bb[d]) begin
         m_err[d] = 1;
         chk("final_reject_flags", 256'(f[2:0]), 256'(3'b001));
      end else begin
         lim = 129'(1) << ll[d];
         sum = m_cnt[d] + 129'(flen);
         if (sum >= lim) begin
            sum = sum - lim;
            m_err[d] = 1;
         end
         len = sum[127:0];
         chk("final_flags", 256'(f[2:0]), 256'({m_first[d], !m_first[d], m_err[d]}));
         m_first[d] = 0;
         chk_blk("final_blk", get_blk(d), exp_first(d, flen, blk, len));
         if (flen >= bb[d] - ll[d]) begin
            extra = 1;
            m_len[d] = len;
            m_flen[d] = flen;
         end
      end
   endtask

   task automatic do_extra(int d);
      logic [3:0] f;
      int n = 0;
      f = get_fl(d);
      chk("extra_busy_ready", 256'(f[3]), 256'(0));
      set_cr(d, 0);
      step();
      step();
      f = get_fl(d);
      chk("extra_early_pulse", 256'(f[2:1]), 256'(0));
      set_cr(d, 1);
      do begin
         step();
         n++;
         f = get_fl(d);
      end while (f[1] !== 1'b1 && n < 10);
      chk("extra_next_out", 256'(f[2:0]), 256'({1'b0, 1'b1, m_err[d]}));
      chk_blk("extra_blk", get_blk(d), exp_extra(d, m_flen[d], m_len[d]));
      step();
      f = get_fl(d);
      chk("extra_after", 256'(f[3:1]), 256'(3'b100));
   endtask

   task automatic run_msg(int d, int nn, int flen, logic [1023:0] blk);
      bit ex;
      do_init(d);
      for (int k = 0; k < nn; k++) do_next(d, rnd_blk());
      do_final(d, flen, blk, ex);
      if (ex) do_extra(d);
   endtask

   initial begin
      logic [1023:0] b;
      logic [3:0]    f;
      bit            ex;
      int            bnd[5];

      reset_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         drive(d, 0, 0, 0, 0, '0);
         set_cr(d, 1);
      end
      #22;
      for (int d = 0; d < 3; d++) begin
         f = get_fl(d);
         chk("reset_flags", 256'(f[2:0]), 256'(0));
         chk_blk("reset_blk", get_blk(d), '0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      step();

      // "abc" in a single SHA-256 block, garbage below the message masked
      do_init(0);
      b = rnd_blk();
      b[1023:512] = '0;
      b[511:488] = 24'h616263;
      do_final(0, 24, b, ex);
      b = get_blk(0);
      chk("abc_len", 256'(b[63:0]), 256'(64'h18));
      chk("abc_top", 256'(b[511:480]), 256'(32'h61626380));
      step();
      f = get_fl(0);
      chk("abc_pulse_end", 256'(f[2:1]), 256'(0));

      // two full blocks then 440 bits: strobes init, next, next
      do_init(0);
      do_next(0, rnd_blk());
      do_next(0, rnd_blk());
      do_final(0, 440, rnd_blk(), ex);
      b = get_blk(0);
      chk("m440_len", 256'(b[63:0]), 256'(64'h5B8));
      chk("m440_pad", 256'(b[71]), 256'(1));

      // 448 bits: no room for length, extra block follows
      do_init(0);
      do_final(0, 448, rnd_blk(), ex);
      b = get_blk(0);
      chk("m448_low", 256'(b[63:0]), 256'(64'h8000_0000_0000_0000));
      chk("m448_extra_flag", 256'(ex), 256'(1));
      if (ex) do_extra(0);
      b = get_blk(0);
      chk("m448_extra_len", b[255:0], 256'(64'h1C0));

      // SHA-512: full final block passes through, extra carries the pad bit
      do_init(1);
      b = rnd_blk();
      do_final(1, 1024, b, ex);
      chk_blk("full_passthru", get_blk(1), b);
      if (ex) do_extra(1);
      b = get_blk(1);
      chk("full_top_bit", 256'(b[1023]), 256'(1));
      chk("full_len", 256'(b[127:0]), 256'(128'h400));
      run_msg(1, 1, 100, rnd_blk());

      // oversize final_len rejected, then init during WAIT_HI aborts
      do_init(0);
      do_final(0, 513, rnd_blk(), ex);
      f = get_fl(0);
      chk("reject_ready", 256'(f[3]), 256'(1));
      do_final(0, 500, rnd_blk(), ex);
      set_cr(0, 0);
      step();
      drive(0, 1, 0, 0, 0, '0);
      step();
      drive(0, 0, 0, 0, 0, '0);
      set_cr(0, 1);
      for (int k = 0; k < 4; k++) begin
         step();
         f = get_fl(0);
         chk("abort_no_extra", 256'(f[2:1]), 256'(0));
      end
      chk("abort_err_clear", 256'({f[3], f[0]}), 256'(2'b10));

      // next_in while core busy is ignored; counter stays zero
      do_init(0);
      set_cr(0, 0);
      drive(0, 0, 1, 0, 0, rnd_blk());
      step();
      step();
      f = get_fl(0);
      chk("busy_ignored", 256'(f[2:1]), 256'(0));
      drive(0, 0, 0, 0, 0, '0);
      set_cr(0, 1);
      do_final(0, 0, rnd_blk(), ex);

      // narrow counter: wrap on next_in, then carry on final length
      run_msg(2, 8, 0, rnd_blk());
      run_msg(2, 7, 512, rnd_blk());
      run_msg(2, 3, 499, rnd_blk());

      // boundary and random final lengths
      bnd = '{0, 447, 448, 511, 512};
      for (int k = 0; k < 5; k++) run_msg(0, k % 3, bnd[k], rnd_blk());
      for (int k = 0; k < 6; k++) begin
         int d;
         d = k % 2;
         run_msg(d, int'($urandom_range(0, 3)), int'($urandom_range(0, bb[d])), rnd_blk());
      end

      // asynchronous reset while a pulse is live and the FSM sits in WAIT_LO
      do_init(0);
      do_final(0, 460, rnd_blk(), ex);
      reset_n = 1'b0;
      #1;
      f = get_fl(0);
      chk("async_rst_flags", 256'(f[2:0]), 256'(0));
      chk_blk("async_rst_blk", get_blk(0), '0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) step();
      f = get_fl(0);
      chk("post_rst_idle", 256'(f), 256'(4'b1000));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
